// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame layout, cache FSM
// state encodings and the default cache geometry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_SETS = 16;

  // Tag field is sized for the smallest useful cache; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       data;
  } icache_frame_t;

  typedef logic [1:0] icache_state_t;
  localparam icache_state_t ICACHE_IDLE     = 2'd0;
  localparam icache_state_t ICACHE_FETCH    = 2'd1;
  localparam icache_state_t ICACHE_PREFETCH = 2'd2;

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame store: two combinational read ports, one synchronous
// write port, valid bits cleared by synchronous reset (tags/data are not).
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter  int unsigned SETS = ICACHE_SETS,
  localparam int unsigned IW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_index,
  output icache_frame_t rd_frame,
  input  logic [IW-1:0] pf_index,
  output icache_frame_t pf_frame,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [29:0]   wr_tag,
  input  word_t         wr_data
);

  logic [SETS-1:0] valid;
  logic [29:0]     tags [SETS];
  word_t           data [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  always_comb begin
    rd_frame = '{valid: valid[rd_index], tag: tags[rd_index], data: data[rd_index]};
    pf_frame = '{valid: valid[pf_index], tag: tags[pf_index], data: data[pf_index]};
  end

endmodule

// File: rtl/icache_prefetch.sv
// Direct-mapped read-only instruction cache with optional next-line prefetch,
// serving hits combinationally and filling misses over the iREN/iwait handshake.
module icache_prefetch
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS        = ICACHE_SETS,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IW = $clog2(SETS);

  function automatic logic [29:0] tag_of(input word_t a);
    return 30'(a[31:IW+2]);
  endfunction

  function automatic logic [IW-1:0] index_of(input word_t a);
    return a[IW+1:2];
  endfunction

  icache_state_t state, state_n;
  word_t         miss_addr, miss_addr_n;
  word_t         pf_addr, pf_addr_n;
  word_t         fill_addr, next_pf;
  icache_frame_t rd_frame, pf_frame;
  logic          busy, done, lookup_hit, fwd, pf_ok, miss_req, miss_inc;
  logic          unused_bits;

  assign unused_bits = ^{imemaddr[1:0], pf_frame.data};

  icache_frames #(.SETS(SETS)) u_frames (
    .clk      (CLK),
    .rst      (nRST),
    .rd_index (index_of(imemaddr)),
    .rd_frame (rd_frame),
    .pf_index (index_of(next_pf)),
    .pf_frame (pf_frame),
    .wr_en    (done),
    .wr_index (index_of(fill_addr)),
    .wr_tag   (tag_of(fill_addr)),
    .wr_data  (iload)
  );

  always_comb begin
    busy       = (state == ICACHE_FETCH) || (state == ICACHE_PREFETCH);
    fill_addr  = (state == ICACHE_PREFETCH) ? pf_addr : miss_addr;
    next_pf    = miss_addr + 32'd4;
    iREN       = busy;
    iaddr      = busy ? fill_addr : '0;
    done       = busy && !iwait;
    // Lookup reads the pre-write array; only the forward path can hit a frame being filled.
    lookup_hit = imemREN && rd_frame.valid && (rd_frame.tag == tag_of(imemaddr));
    fwd        = done && imemREN && (imemaddr[31:2] == fill_addr[31:2]);
    ihit       = lookup_hit || fwd;
    imemload   = fwd ? iload : (lookup_hit ? rd_frame.data : '0);
    miss_req   = imemREN && !ihit;
    pf_ok      = PREFETCH_EN && (miss_addr != 32'hFFFF_FFFC) &&
                 !(pf_frame.valid && (pf_frame.tag == tag_of(next_pf)));
  end

  always_comb begin
    state_n     = state;
    miss_addr_n = miss_addr;
    pf_addr_n   = pf_addr;
    miss_inc    = 1'b0;
    case (state)
      ICACHE_IDLE: begin
        if (miss_req) begin
          state_n     = ICACHE_FETCH;
          miss_addr_n = {imemaddr[31:2], 2'b00};
          miss_inc    = 1'b1;
        end
      end
      ICACHE_FETCH: begin
        if (done) begin
          if (pf_ok) begin
            state_n   = ICACHE_PREFETCH;
            pf_addr_n = next_pf;
          end else begin
            state_n = ICACHE_IDLE;
          end
        end
      end
      ICACHE_PREFETCH: begin
        // Misses wait for the prefetch to land; the request is never withdrawn.
        if (done) begin
          if (miss_req) begin
            state_n     = ICACHE_FETCH;
            miss_addr_n = {imemaddr[31:2], 2'b00};
            miss_inc    = 1'b1;
          end else begin
            state_n = ICACHE_IDLE;
          end
        end
      end
      default: state_n = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state      <= ICACHE_IDLE;
      miss_addr  <= '0;
      pf_addr    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state     <= state_n;
      miss_addr <= miss_addr_n;
      pf_addr   <= pf_addr_n;
      if (ihit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_inc && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache_prefetch.sv
// Directed bench for icache_prefetch: a latency-3 memory responder, a queue of
// expected instruction words, and immediate-assertion checks at each step.
module tb_icache_prefetch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          lat   = 3;
  int          wcnt  = 0;
  logic [31:0] sb [$];

  icache_prefetch #(.SETS(16), .PREFETCH_EN(1'b1)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'h1);
  endfunction

  // Memory controller model: lat cycles of iwait=1, then one cycle of iwait=0 with data.
  always @(posedge CLK) begin
    #1;
    if (iREN === 1'b1) begin
      if (wcnt == lat) begin
        iwait = 1'b0;
        iload = mem(iaddr);
        wcnt  = 0;
      end else begin
        iwait = 1'b1;
        iload = '0;
        wcnt++;
      end
    end else begin
      iwait = 1'b1;
      iload = '0;
      wcnt  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one fetch and wait for its ihit; cyc counts miss cycles before the hit.
  task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] iaddr0,
                       output logic iren0, output logic [31:0] hit_iaddr);
    logic [31:0] expv;
    imemREN   = 1'b1;
    imemaddr  = a;
    sb.push_back(mem(a));
    cyc       = 0;
    hit_iaddr = '0;
    @(negedge CLK);
    iaddr0 = iaddr;
    iren0  = iREN;
    while (ihit !== 1'b1 && cyc < 60) begin
      cyc++;
      @(negedge CLK);
    end
    expv = sb.pop_front();
    if (ihit === 1'b1) begin
      hit_iaddr = (iREN === 1'b1) ? iaddr : '0;
      check("imemload", imemload, expv);
    end else begin
      check("ihit_timeout", {31'b0, ihit}, 32'd1);
    end
    @(posedge CLK);
    #2;
    imemREN = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    imemREN = 1'b0;
    n = 0;
    @(negedge CLK);
    while (iREN !== 1'b0 && n < 60) begin
      n++;
      @(negedge CLK);
    end
    check("idle_reached", {31'b0, iREN}, 32'd0);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int          cyc;
    int          n;
    logic [31:0] a0;
    logic [31:0] ha;
    logic        r0;

    nRST     = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b0;
    @(negedge CLK);
    check("rst_iREN", {31'b0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    @(posedge CLK);
    #2;

    // Cold miss at 0x40, then background prefetch of 0x44.
    fetch(32'h40, cyc, a0, r0, ha);
    check("cold_latency", cyc, 32'd4);
    check("cold_iaddr", ha, 32'h40);
    check("cold_misses", miss_count, 32'd1);
    @(negedge CLK);
    check("cold_pf_iREN", {31'b0, iREN}, 32'd1);
    check("cold_pf_iaddr", iaddr, 32'h44);
    wait_idle();

    // Re-access hit.
    fetch(32'h40, cyc, a0, r0, ha);
    check("rehit_latency", cyc, 32'd0);
    check("rehit_iREN", {31'b0, r0}, 32'd0);
    check("rehit_hits", hit_count, 32'd2);
    check("rehit_misses", miss_count, 32'd1);
    wait_idle();

    // Prefetch of 0x104 after a miss at 0x100, then a zero-latency hit on 0x104.
    fetch(32'h100, cyc, a0, r0, ha);
    check("pf_miss_latency", cyc, 32'd4);
    @(negedge CLK);
    check("pf_iREN", {31'b0, iREN}, 32'd1);
    check("pf_iaddr", iaddr, 32'h104);
    wait_idle();
    fetch(32'h104, cyc, a0, r0, ha);
    check("pf_hit_latency", cyc, 32'd0);
    check("pf_hit_misses", miss_count, 32'd2);

    // Miss at 0x200 while the prefetch of 0x304 is pending.
    fetch(32'h300, cyc, a0, r0, ha);
    check("m300_latency", cyc, 32'd4);
    fetch(32'h200, cyc, a0, r0, ha);
    check("mdp_pending_iaddr", a0, 32'h304);
    check("mdp_latency", cyc, 32'd7);
    check("mdp_fetch_iaddr", ha, 32'h200);
    check("mdp_misses", miss_count, 32'd4);
    wait_idle();

    // Conflict on index 0, and a prefetch suppressed because the next line is resident.
    fetch(32'h40, cyc, a0, r0, ha);
    check("conf_40_latency", cyc, 32'd4);
    wait_idle();
    fetch(32'h84, cyc, a0, r0, ha);
    check("conf_84_latency", cyc, 32'd4);
    wait_idle();
    fetch(32'h80, cyc, a0, r0, ha);
    check("conf_80_latency", cyc, 32'd4);
    @(negedge CLK);
    check("pf_skip_resident", {31'b0, iREN}, 32'd0);
    @(posedge CLK);
    #2;
    fetch(32'h40, cyc, a0, r0, ha);
    check("conf_40_again", cyc, 32'd4);
    check("conf_misses", miss_count, 32'd8);
    wait_idle();

    // Top-of-memory miss: no wrap-around prefetch.
    fetch(32'hFFFF_FFFC, cyc, a0, r0, ha);
    check("wrap_latency", cyc, 32'd4);
    @(negedge CLK);
    check("wrap_no_pf", {31'b0, iREN}, 32'd0);
    check("wrap_hits", hit_count, 32'd11);
    check("wrap_misses", miss_count, 32'd9);
    @(posedge CLK);
    #2;

    // Reset in the middle of a FETCH.
    fetch(32'h40, cyc, a0, r0, ha);
    check("pre_rst_hit", cyc, 32'd0);
    imemREN  = 1'b1;
    imemaddr = 32'h330;
    n = 0;
    @(negedge CLK);
    while (iREN !== 1'b1 && n < 20) begin
      n++;
      @(negedge CLK);
    end
    check("mid_fetch_iREN", {31'b0, iREN}, 32'd1);
    @(posedge CLK);
    #2;
    nRST     = 1'b1;
    imemaddr = 32'h40;
    @(posedge CLK);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("mrst_iREN", {31'b0, iREN}, 32'd0);
    check("mrst_iaddr", iaddr, 32'd0);
    check("mrst_ihit", {31'b0, ihit}, 32'd0);
    check("mrst_imemload", imemload, 32'd0);
    check("mrst_hits", hit_count, 32'd0);
    check("mrst_misses", miss_count, 32'd0);
    @(posedge CLK);
    #2;
    fetch(32'h40, cyc, a0, r0, ha);
    check("mrst_refill_latency", cyc, 32'd4);
    check("mrst_refill_misses", miss_count, 32'd1);
    check("mrst_refill_hits", hit_count, 32'd1);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
